// File: rtl/alu_op_scheduler.sv
// Two-requester round-robin scheduler that sequences the 8-bit add/sub unit.
// Each accepted op gets a two-cycle issue window; NEG chains NOT then INC.
module alu_op_scheduler #(
  localparam int unsigned DATA_W = 8,
  localparam int unsigned OP_W   = 4,
  localparam int unsigned SEL_W  = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0_Valid,
  output logic              Req0_Ready,
  input  logic [OP_W-1:0]   Req0_Op,
  input  logic [DATA_W-1:0] Req0_A,
  input  logic [DATA_W-1:0] Req0_B,
  input  logic              Req1_Valid,
  output logic              Req1_Ready,
  input  logic [OP_W-1:0]   Req1_Op,
  input  logic [DATA_W-1:0] Req1_A,
  input  logic [DATA_W-1:0] Req1_B,
  output logic [OP_W-1:0]   Alu_Opcode,
  output logic [DATA_W-1:0] Alu_A,
  output logic [DATA_W-1:0] Alu_B,
  output logic [SEL_W-1:0]  Alu_Select,
  input  logic [DATA_W-1:0] Alu_Result,
  input  logic              Alu_Flag,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_Data,
  output logic              Rsp_Id,
  output logic              Rsp_Err
);

  localparam logic [OP_W-1:0]  OP_NONE = OP_W'(0);
  localparam logic [OP_W-1:0]  OP_INC  = OP_W'(1);
  localparam logic [OP_W-1:0]  OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0]  OP_SUB  = OP_W'(3);
  localparam logic [OP_W-1:0]  OP_DEC  = OP_W'(4);
  localparam logic [OP_W-1:0]  OP_NOT  = OP_W'(5);
  localparam logic [OP_W-1:0]  OP_NEG  = OP_W'(6);
  localparam logic [SEL_W-1:0] SEL_OFF = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_ON  = SEL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                id_q, id_d;
  logic                step_q, step_d;
  logic [DATA_W-1:0]   inter_q, inter_d;
  logic                last_q, last_d;
  logic [OP_W-1:0]     alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;

  logic                any_valid_c;
  logic                grant_c;
  logic                ready0_c;
  logic                ready1_c;
  logic [OP_W-1:0]     gnt_op_c;
  logic [DATA_W-1:0]   gnt_a_c;
  logic [DATA_W-1:0]   gnt_b_c;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_INC) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_DEC) || (op == OP_NOT) || (op == OP_NEG);
  endfunction

  // Round-robin pick: with both requesting, serve the one not served last.
  always_comb begin
    any_valid_c = Req0_Valid | Req1_Valid;
    grant_c     = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
      grant_c = ~last_q;
    end else if (Req1_Valid) begin
      grant_c = 1'b1;
    end
    ready0_c = Reset_n && (state_q == S_IDLE) && Req0_Valid && !grant_c;
    ready1_c = Reset_n && (state_q == S_IDLE) && Req1_Valid && grant_c;
    gnt_op_c = grant_c ? Req1_Op : Req0_Op;
    gnt_a_c  = grant_c ? Req1_A  : Req0_A;
    gnt_b_c  = grant_c ? Req1_B  : Req0_B;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    step_d       = step_q;
    inter_d      = inter_q;
    last_d       = last_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    alu_sel_d    = SEL_OFF;
    alu_opcode_d = OP_NONE;
    alu_a_d      = '0;
    alu_b_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid_c) begin
          op_d   = gnt_op_c;
          a_d    = gnt_a_c;
          b_d    = gnt_b_c;
          id_d   = grant_c;
          step_d = 1'b0;
          if (op_legal(gnt_op_c)) begin
            state_d = S_EXEC1;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_id_d   = grant_c;
            state_d    = S_RESP;
          end
        end
      end
      S_EXEC1: state_d = S_EXEC2;
      S_EXEC2: state_d = S_CAPT;
      S_CAPT: begin
        if ((op_q == OP_NEG) && !step_q) begin
          inter_d = Alu_Result;
          step_d  = 1'b1;
          state_d = S_EXEC1;
        end else begin
          rsp_data_d = Alu_Result;
          rsp_err_d  = ~Alu_Flag;
          rsp_id_d   = id_q;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (Rsp_Ready) begin
          last_d  = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Unit inputs are registered from the upcoming state so they hold for both edges.
    if ((state_d == S_EXEC1) || (state_d == S_EXEC2)) begin
      alu_sel_d = SEL_ON;
      if (op_d == OP_NEG) begin
        alu_opcode_d = step_d ? OP_INC : OP_NOT;
        alu_a_d      = step_d ? inter_d : a_d;
        alu_b_d      = step_d ? DATA_W'(0) : b_d;
      end else begin
        alu_opcode_d = op_d;
        alu_a_d      = a_d;
        alu_b_d      = b_d;
      end
    end
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NONE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      step_q       <= 1'b0;
      inter_q      <= '0;
      last_q       <= 1'b1;
      alu_opcode_q <= OP_NONE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= SEL_OFF;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      step_q       <= step_d;
      inter_q      <= inter_d;
      last_q       <= last_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign Req0_Ready = ready0_c;
  assign Req1_Ready = ready1_c;
  assign Alu_Opcode = alu_opcode_q;
  assign Alu_A      = alu_a_q;
  assign Alu_B      = alu_b_q;
  assign Alu_Select = alu_sel_q;
  assign Rsp_Valid  = rsp_valid_q;
  assign Rsp_Data   = rsp_data_q;
  assign Rsp_Id     = rsp_id_q;
  assign Rsp_Err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler with a behavioural model of the adder/subtractor unit.
module tb_alu_op_scheduler;

  localparam logic [3:0] OP_INC = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_NEG = 4'd6;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk, rst_n;
  logic v0, r0, v1, r1;
  logic [3:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_sel;
  logic alu_flag, force_flag_low;
  logic rsp_v, rsp_rdy, rsp_id, rsp_err;
  logic [7:0] rsp_d;

  int checks = 0;
  int errors = 0;
  int sel_cnt = 0;
  int idle_bad = 0;
  logic [19:0] sel_log[$];
  exp_t sb_q[$];

  alu_op_scheduler dut (
    .Clk(clk), .Reset_n(rst_n),
    .Req0_Valid(v0), .Req0_Ready(r0), .Req0_Op(op0), .Req0_A(a0), .Req0_B(b0),
    .Req1_Valid(v1), .Req1_Ready(r1), .Req1_Op(op1), .Req1_A(a1), .Req1_B(b1),
    .Alu_Opcode(alu_op), .Alu_A(alu_a), .Alu_B(alu_b), .Alu_Select(alu_sel),
    .Alu_Result(alu_res), .Alu_Flag(alu_flag),
    .Rsp_Valid(rsp_v), .Rsp_Ready(rsp_rdy), .Rsp_Data(rsp_d), .Rsp_Id(rsp_id),
    .Rsp_Err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd6);
  endfunction

  function automatic logic [7:0] ref_result(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    case (op)
      4'd1:    return 8'(a + 8'd1);
      4'd2:    return 8'(a + b);
      4'd3:    return 8'(a - b);
      4'd4:    return 8'(a - 8'd1);
      4'd5:    return ~a;
      4'd6:    return 8'((~a) + 8'd1);
      default: return 8'h00;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic id, input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b);
    exp_t e;
    e.id   = id;
    e.data = is_legal(op) ? ref_result(op, a, b) : 8'h00;
    e.err  = !is_legal(op) || force_flag_low;
    return e;
  endfunction

  // Unit model: registers a result on every edge where it is selected.
  always @(posedge clk) begin
    if (alu_sel == 3'b001) begin
      alu_res  <= (alu_op >= 4'd1 && alu_op <= 4'd5) ? ref_result(alu_op, alu_a, alu_b) : 8'h00;
      alu_flag <= (alu_op >= 4'd1 && alu_op <= 4'd5) && !force_flag_low;
    end
  end

  always @(negedge clk) begin
    #2;
    if (alu_sel == 3'b001) begin
      sel_cnt++;
      sel_log.push_back({alu_op, alu_a, alu_b});
    end else if (alu_sel != 3'b000 || alu_op != 4'd0) begin
      idle_bad++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Drive a request from a negedge; returns on the negedge after the accept edge.
  task automatic issue(input logic id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, output logic ok);
    ok = 1'b0;
    if (id) begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if ((id ? r1 : r0) === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      sb_q.push_back(make_exp(id, op, a, b));
      @(negedge clk);
    end
    if (id) v1 = 1'b0; else v0 = 1'b0;
  endtask

  // Wait for a response, consume it, and report cycles since the accept edge.
  task automatic wait_rsp(output logic ok, output int lat, output exp_t got);
    ok  = 1'b0;
    lat = 1;
    got = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (rsp_v === 1'b1) begin
        ok  = 1'b1;
        got = {rsp_id, rsp_d, rsp_err};
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (ok) begin
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 1'b1; op0 = OP_ADD; a0 = 8'h11; b0 = 8'h22;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({r0, r1, alu_op, alu_a, alu_b, alu_sel, rsp_v, rsp_d, rsp_id, rsp_err} !== 36'd0)
      begin errors++; $display("FAIL reset_values: got %h expected 0",
        {r0, r1, alu_op, alu_a, alu_b, alu_sel, rsp_v, rsp_d, rsp_id, rsp_err}); end
    v0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic ok; int lat; exp_t got, e; logic [19:0] l0, l1;
    sel_cnt = 0; sel_log.delete();
    issue(1'b0, OP_ADD, 8'h12, 8'h34, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL add_accept: got %b expected 1", ok); end
    wait_rsp(ok, lat, got);
    checks++;
    if (ok !== 1'b1 || lat != 4) begin errors++;
      $display("FAIL add_latency: got ok=%b lat=%0d expected ok=1 lat=4", ok, lat); end
    e = sb_q.pop_front();
    checks++;
    if (got !== e || e.data !== 8'h46) begin errors++;
      $display("FAIL add_rsp: got %h expected %h", got, e); end
    checks++;
    if (sel_cnt != 2) begin errors++; $display("FAIL add_sel_cycles: got %0d expected 2", sel_cnt); end
    if (sel_log.size() >= 2) begin
      l0 = sel_log[0]; l1 = sel_log[1];
      checks++;
      if (l0 !== {OP_ADD, 8'h12, 8'h34} || l1 !== l0) begin errors++;
        $display("FAIL add_issue: got %h %h expected %h", l0, l1, {OP_ADD, 8'h12, 8'h34}); end
    end
  endtask

  task automatic test_neg();
    logic ok; int lat; exp_t got, e; logic [19:0] l0, l1, l2, l3;
    sel_cnt = 0; sel_log.delete();
    issue(1'b1, OP_NEG, 8'h05, 8'h00, ok);
    wait_rsp(ok, lat, got);
    checks++;
    if (ok !== 1'b1 || lat != 7) begin errors++;
      $display("FAIL neg_latency: got ok=%b lat=%0d expected ok=1 lat=7", ok, lat); end
    e = sb_q.pop_front();
    checks++;
    if (got !== e || e.data !== 8'hFB || got.id !== 1'b1) begin errors++;
      $display("FAIL neg_rsp: got %h expected %h", got, e); end
    checks++;
    if (sel_cnt != 4 || sel_log.size() != 4) begin errors++;
      $display("FAIL neg_sel_cycles: got %0d expected 4", sel_cnt); end
    else begin
      l0 = sel_log[0]; l1 = sel_log[1]; l2 = sel_log[2]; l3 = sel_log[3];
      checks++;
      if (l0[19:8] !== {4'h5, 8'h05} || l1 !== l0) begin errors++;
        $display("FAIL neg_step0: got %h %h expected %h", l0, l1, {4'h5, 8'h05}); end
      checks++;
      if (l2 !== {OP_INC, 8'hFA, 8'h00} || l3 !== l2) begin errors++;
        $display("FAIL neg_step1: got %h %h expected %h", l2, l3, {OP_INC, 8'hFA, 8'h00}); end
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, nr; int grants[$]; int exp_g[4]; exp_t got, e;
    exp_g = '{0, 1, 0, 1};
    t0 = 0; t1 = 0; nr = 0;
    v0 = 1'b1; op0 = OP_SUB; a0 = 8'h10; b0 = 8'h01;
    v1 = 1'b1; op1 = OP_INC; a1 = 8'hFF; b1 = 8'h00;
    rsp_rdy = 1'b1;
    for (int c = 0; c < 100 && nr < 4; c++) begin
      #1;
      if (v0 && r0 === 1'b1) begin grants.push_back(0); sb_q.push_back(make_exp(1'b0, op0, a0, b0)); t0++; end
      if (v1 && r1 === 1'b1) begin grants.push_back(1); sb_q.push_back(make_exp(1'b1, op1, a1, b1)); t1++; end
      if (rsp_v === 1'b1) begin
        got = {rsp_id, rsp_d, rsp_err};
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
        checks++;
        if (got !== e) begin errors++; $display("FAIL b2b_rsp%0d: got %h expected %h", nr, got, e); end
        nr++;
      end
      @(negedge clk);
      v0 = (t0 < 2); v1 = (t1 < 2);
    end
    rsp_rdy = 1'b0; v0 = 1'b0; v1 = 1'b0;
    checks++;
    if (nr != 4 || grants.size() != 4) begin errors++;
      $display("FAIL b2b_count: got rsp=%0d grants=%0d expected 4 4", nr, grants.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] != exp_g[i]) begin errors++;
          $display("FAIL b2b_grant%0d: got %0d expected %0d", i, grants[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_illegal();
    logic ok; int lat; exp_t got, e;
    logic [3:0] ops[2]; logic ids[2];
    ops = '{4'hF, 4'h0}; ids = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      sel_cnt = 0;
      issue(ids[k], ops[k], 8'hAA, 8'h55, ok);
      wait_rsp(ok, lat, got);
      e = sb_q.pop_front();
      checks++;
      if (ok !== 1'b1 || lat != 1) begin errors++;
        $display("FAIL illegal%0d_latency: got ok=%b lat=%0d expected ok=1 lat=1", k, ok, lat); end
      checks++;
      if (got !== e || got.err !== 1'b1 || got.data !== 8'h00) begin errors++;
        $display("FAIL illegal%0d_rsp: got %h expected %h", k, got, e); end
      checks++;
      if (sel_cnt != 0) begin errors++; $display("FAIL illegal%0d_sel: got %0d expected 0", k, sel_cnt); end
    end
  endtask

  task automatic test_flag_err();
    logic ok; int lat; exp_t got, e;
    force_flag_low = 1'b1;
    issue(1'b0, OP_SUB, 8'h03, 8'h05, ok);
    wait_rsp(ok, lat, got);
    force_flag_low = 1'b0;
    e = sb_q.pop_front();
    checks++;
    if (got !== e || got.err !== 1'b1 || got.data !== 8'hFE) begin errors++;
      $display("FAIL flag_err_rsp: got %h expected %h", got, e); end
  endtask

  task automatic test_stall();
    logic ok; int lat, n; exp_t got, e;
    issue(1'b0, OP_DEC, 8'h00, 8'h00, ok);
    n = 0;
    #1;
    while (n < 20 && rsp_v !== 1'b1) begin @(negedge clk); #1; n++; end
    checks++;
    if (rsp_v !== 1'b1) begin errors++; $display("FAIL stall_rsp_timeout: got %b expected 1", rsp_v); end
    e = sb_q.pop_front();
    v1 = 1'b1; op1 = OP_INC; a1 = 8'h05; b1 = 8'h00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({rsp_v, rsp_d, rsp_id, rsp_err, r0, r1} !== {1'b1, e.data, e.id, e.err, 2'b00} ||
          e.data !== 8'hFF) begin errors++;
        $display("FAIL stall_hold%0d: got %h expected %h", c, {rsp_v, rsp_d, rsp_id, rsp_err, r0, r1},
                 {1'b1, e.data, e.id, e.err, 2'b00}); end
    end
    @(negedge clk);
    rsp_rdy = 1'b1;
    #1;
    checks++;
    if (r1 !== 1'b0) begin errors++; $display("FAIL stall_early_grant: got %b expected 0", r1); end
    @(negedge clk);
    rsp_rdy = 1'b0;
    #1;
    checks++;
    if (r1 !== 1'b1 || rsp_v !== 1'b0) begin errors++;
      $display("FAIL stall_next_grant: got ready=%b valid=%b expected 1 0", r1, rsp_v); end
    sb_q.push_back(make_exp(1'b1, OP_INC, 8'h05, 8'h00));
    @(negedge clk);
    v1 = 1'b0;
    wait_rsp(ok, lat, got);
    e = sb_q.pop_front();
    checks++;
    if (ok !== 1'b1 || got !== e || got.data !== 8'h06) begin errors++;
      $display("FAIL stall_followup: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_mid();
    logic ok; int lat; exp_t got, e;
    issue(1'b0, OP_ADD, 8'h01, 8'h02, ok);
    @(negedge clk);
    v1 = 1'b1; op1 = OP_INC; a1 = 8'h7F; b1 = 8'h00;
    checks++;
    if (alu_sel !== 3'b001) begin errors++; $display("FAIL mid_exec2_sel: got %b expected 001", alu_sel); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r0, r1, alu_op, alu_a, alu_b, alu_sel, rsp_v, rsp_d, rsp_id, rsp_err} !== 36'd0)
      begin errors++; $display("FAIL mid_reset_values: got %h expected 0",
        {r0, r1, alu_op, alu_a, alu_b, alu_sel, rsp_v, rsp_d, rsp_id, rsp_err}); end
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (r1 !== 1'b1 || r0 !== 1'b0 || rsp_v !== 1'b0) begin errors++;
      $display("FAIL mid_regrant: got r0=%b r1=%b rsp_v=%b expected 0 1 0", r0, r1, rsp_v); end
    sb_q.push_back(make_exp(1'b1, OP_INC, 8'h7F, 8'h00));
    @(negedge clk);
    v1 = 1'b0;
    wait_rsp(ok, lat, got);
    e = sb_q.pop_front();
    checks++;
    if (ok !== 1'b1 || lat != 4 || got !== e || got.data !== 8'h80) begin errors++;
      $display("FAIL mid_followup: got %h lat=%0d expected %h lat=4", got, lat, e); end
  endtask

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_rdy = 1'b0; force_flag_low = 1'b0;
    op0 = 4'd0; op1 = 4'd0; a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_neg();
    test_back_to_back();
    test_illegal();
    test_flag_err();
    test_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", idle_bad); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
